decode_issue_queue: RTL and testbench
=====================================

// Module: decode_issue_queue
// PURPOSE
//  Registered successor of the combinational ARM decoder. Accepts fetched instructions over valid/ready,
//  decodes them into a control bundle and buffers {ctrl,instr} in a DEPTH-entry FIFO toward Execute.
//  Sequences multi-cycle MUL/DIV through the MCycle unit: start pulse, busy wait, timeout detect.
//  Sits between Fetch and Execute in the non-stalling multi-cycle core; Flush squashes on taken branch/PC write.
// PARAMETERS
//  DEPTH        2   FIFO entries; power of 2, >=2
//  MC_TIMEOUT   64  max cycles in MC_WAIT before McTimeout sets; >=2
//  CNT_W        7   timeout counter width; must hold MC_TIMEOUT
// PORTS
//  CLK              in   1     clock, rising edge
//  RESETn           in   1     asynchronous, active-low reset
//  Flush            in   1     squash all queued entries and any pending start
//  InstrIn          in   32    fetched instruction
//  InstrValid       in   1     InstrIn valid
//  InstrReady       out  1     = !full && !Flush; no combinational path from OutReady
//  CtrlOut          out  18    head control bundle (layout in decoder_pkg.vh)
//  InstrOut         out  32    head instruction
//  OutValid         out  1     head valid toward Execute
//  OutReady         in   1     Execute accepts head
//  Start_MCycle     out  1     one-cycle start pulse to MCycle
//  MCycleOp_MCycle  out  1     0=MUL, 1=DIV; stable from start through busy wait
//  MCycle_Busy      in   1     MCycle busy
//  Undef            out  1     head entry is an undefined encoding
//  McTimeout        out  1     sticky; set when MC_WAIT reaches MC_TIMEOUT cycles
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, all outputs 0 (InstrReady=1 from first cycle after RESETn high).
//  Decode: combinational on InstrIn; push {ctrl,instr} when InstrValid&&InstrReady. Latency 1 cycle to head.
//  Ctrl fields: RegW, MemW, MemtoReg, ALUSrc, ImmSrc[1:0], RegSrc[1:0], ALUControl[3:0], FlagW[1:0],
//   NoWrite, PCS, IsMC, MCOp. DP: ALUControl=funct[4:1]; NoWrite for cmd 1000..1011;
//   FlagW=00 if S=0, 11 for cmd 0010..0111 and 1010..1011, else 10. MEM: ALUControl=U?0100:0010. Branch: 0100.
//  MUL: [27:21]=0 && [7:4]=1001 -> IsMC=1, MCOp=0.
//  Pop: OutValid&&OutReady at edge. Simultaneous push+pop when full: pop only (InstrReady was 0).
//  Pointers wrap modulo DEPTH; count is PTR_W+1 bits.
//  FSM: IDLE -> START when head valid && IsMC && !MCycle_Busy; START (1 cyc): Start_MCycle=1, OutValid=0
//   -> MC_WAIT; MC_WAIT: OutValid=0 until MCycle_Busy=0 (first sampled the cycle after START) -> DONE;
//   DONE: OutValid=1, hold until OutReady, then pop and -> IDLE. Non-MC head: OutValid=1 in IDLE.
//  Timeout: counter clears on START, increments each MC_WAIT cycle; at MC_TIMEOUT sets McTimeout (sticky
//   until reset); FSM remains in MC_WAIT.
//  Flush (priority over push/pop): FIFO empties at the edge, FSM -> IDLE, counter clears; in-flight MCycle
//   op is not cancelled: IDLE start guard (!MCycle_Busy) blocks the next start until it finishes.
//  Reset mid-operation: everything returns to reset values asynchronously; no partial state survives.
// CONFIGURATION
//  DECODER_DIV_EN defined: [27:20]=0111_1111 && [7:4]=1111 decodes as IsMC=1, MCOp=1 (divide).
//  Not defined: that encoding sets Undef=1 with RegW=MemW=0, IsMC=0; it passes through the FIFO and never
//   starts MCycle.
// STRUCTURE
//  decoder_pkg.vh: CTRL_W, field bit offsets, FSM encodings (IDLE/START/MC_WAIT/DONE), op/cmd constants.
//  Sub-module decode_ctrl_comb: pure combinational Instr -> ctrl bundle. FIFO and FSM live in this module.
// TESTING
//  0xE2821005 (ADD R1,R2,#5), OutReady=1 -> next cycle OutValid=1, ALUControl=0100, RegW=1, ALUSrc=1, FlagW=00.
//  0xE3510000 (CMP R1,#0) -> NoWrite=1, FlagW=11, ALUControl=1010.
//  0xE5821004 (STR) -> MemW=1, RegW=0, ImmSrc=01, RegSrc=10, ALUControl=0100.
//  0xE0000291 (MUL), Busy high 4 cycles -> one Start_MCycle pulse, MCOp=0, OutValid rises the cycle after
//   Busy falls.
//  OutReady=0, push 3 instrs with DEPTH=2 -> InstrReady=0 after 2nd; Flush -> OutValid=0 and InstrReady=1
//   next cycle.
//  0xE7F000F0: with DECODER_DIV_EN -> start, MCOp=1; Busy held 70 cycles -> McTimeout=1; without macro -> Undef=1.

Source files
------------

// File: rtl/decode_issue_queue_pkg.sv
// decode_issue_queue_pkg
//   Shared definitions for the decode/issue queue: control bundle layout,
//   opcode and ALU command constants, and the MCycle sequencing FSM encoding.
//   Optional feature macro: DECODER_DIV_EN (see decode_ctrl_comb).
package decode_issue_queue_pkg;

    localparam int CTRL_W  = 18;
    localparam int INSTR_W = 32;

    // The packed struct is the 18-bit CtrlOut layout; regw sits at bit 0 and
    // mcop at bit 17.
    typedef struct packed {
        logic       mcop;
        logic       ismc;
        logic       pcs;
        logic       nowrite;
        logic [1:0] flagw;
        logic [3:0] aluctl;
        logic [1:0] regsrc;
        logic [1:0] immsrc;
        logic       alusrc;
        logic       memtoreg;
        logic       memw;
        logic       regw;
    } ctrl_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_MC_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } mc_state_e;

endpackage

// File: rtl/decode_issue_queue_decode_ctrl.sv
// decode_ctrl_comb
//   Pure combinational ARM instruction -> control bundle decoder.
//   Ports:
//     instr_i  [31:0]  instruction to decode
//     ctrl_o   [17:0]  control bundle (ctrl_t layout)
//     undef_o          encoding is not recognised
//   Macro DECODER_DIV_EN: when defined, [27:20]=0x7F with [7:4]=1111 decodes
//   as a multi-cycle divide; otherwise that encoding is reported undefined.
module decode_ctrl_comb
    import decode_issue_queue_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output ctrl_t              ctrl_o,
    output logic               undef_o
);

    logic [1:0] op;
    logic [3:0] cmd;
    logic       s_bit;
    logic       is_mul;
    logic       is_div;
    logic       unused_instr_bits;

    assign op     = instr_i[27:26];
    assign cmd    = instr_i[24:21];
    assign s_bit  = instr_i[20];
    assign is_mul = (instr_i[27:21] == 7'd0) && (instr_i[7:4] == 4'b1001);
    assign is_div = (instr_i[27:20] == 8'h7F) && (instr_i[7:4] == 4'b1111);

    // Condition, Rn, rotate and low operand fields do not affect control.
    assign unused_instr_bits = ^{instr_i[31:28], instr_i[19:16], instr_i[11:8], instr_i[3:0]};

    always_comb begin
        ctrl_o  = '0;
        undef_o = 1'b0;
        case (op)
            OP_DP: begin
                ctrl_o.regw    = 1'b1;
                ctrl_o.alusrc  = instr_i[25];
                ctrl_o.immsrc  = IMM_DP;
                ctrl_o.aluctl  = cmd;
                ctrl_o.nowrite = (cmd[3:2] == 2'b10);
                if (s_bit) begin
                    if (((cmd >= 4'b0010) && (cmd <= 4'b0111)) || (cmd == 4'b1010) || (cmd == 4'b1011)) begin
                        ctrl_o.flagw = 2'b11;
                    end else begin
                        ctrl_o.flagw = 2'b10;
                    end
                end
                if (is_mul) begin
                    ctrl_o         = '0;
                    ctrl_o.regw    = 1'b1;
                    ctrl_o.ismc    = 1'b1;
                    ctrl_o.mcop    = 1'b0;
                end
            end
            OP_MEM: begin
                if (is_div) begin
`ifdef DECODER_DIV_EN
                    ctrl_o.regw = 1'b1;
                    ctrl_o.ismc = 1'b1;
                    ctrl_o.mcop = 1'b1;
`else
                    undef_o = 1'b1;
`endif
                end else begin
                    ctrl_o.alusrc = 1'b1;
                    ctrl_o.immsrc = IMM_MEM;
                    ctrl_o.aluctl = instr_i[23] ? ALU_ADD : ALU_SUB;
                    if (s_bit) begin
                        ctrl_o.regw     = 1'b1;
                        ctrl_o.memtoreg = 1'b1;
                    end else begin
                        ctrl_o.memw   = 1'b1;
                        ctrl_o.regsrc = 2'b10;
                    end
                end
            end
            OP_BR: begin
                ctrl_o.pcs    = 1'b1;
                ctrl_o.alusrc = 1'b1;
                ctrl_o.immsrc = IMM_BR;
                ctrl_o.regsrc = 2'b01;
                ctrl_o.aluctl = ALU_ADD;
            end
            default: begin
                undef_o = 1'b1;
            end
        endcase
        // A register write to R15 redirects the PC; MUL keeps Rd elsewhere.
        if (ctrl_o.regw && !ctrl_o.nowrite && !ctrl_o.ismc && (instr_i[15:12] == 4'hF)) begin
            ctrl_o.pcs = 1'b1;
        end
    end

endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue
//   Registered decode stage: decodes fetched instructions, buffers
//   {undef,ctrl,instr} in a DEPTH-entry FIFO toward Execute, and sequences
//   multi-cycle MUL/DIV heads through the MCycle unit.
//   Ports:
//     CLK, RESETn           clock, async active-low reset
//     Flush                 squash queue and pending start
//     InstrIn/InstrValid/InstrReady    fetch side
//     CtrlOut/InstrOut/OutValid/OutReady/Undef   execute side (head entry)
//     Start_MCycle/MCycleOp_MCycle/MCycle_Busy   MCycle handshake
//     McTimeout             sticky MC_WAIT timeout flag
//   Macro DECODER_DIV_EN enables the divide encoding in decode_ctrl_comb.
//
//   state    | meaning
//   IDLE     | head issued directly, or MC head waits for MCycle idle
//   START    | one-cycle Start_MCycle pulse
//   MC_WAIT  | waiting for MCycle_Busy low, timeout counter running
//   DONE     | MC result ready, head offered until accepted
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               Flush,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic               InstrValid,
    output logic               InstrReady,
    output logic [CTRL_W-1:0]  CtrlOut,
    output logic [INSTR_W-1:0] InstrOut,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               Start_MCycle,
    output logic               MCycleOp_MCycle,
    input  logic               MCycle_Busy,
    output logic               Undef,
    output logic               McTimeout
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + CTRL_W + INSTR_W;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(MC_TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_ONE  = CNT_W'(1);

    ctrl_t              dec_ctrl;
    logic               dec_undef;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               ready_en_q;
    mc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
    logic               mc_op_q, mc_op_d;

    logic               head_valid, push, pop, out_valid, start;
    logic [ENTRY_W-1:0] head_entry;
    ctrl_t              head_ctrl;

    decode_ctrl_comb u_decode (
        .instr_i (InstrIn),
        .ctrl_o  (dec_ctrl),
        .undef_o (dec_undef)
    );

    assign head_valid = (count_q != '0);
    assign head_entry = mem_q[rd_ptr_q];
    assign head_ctrl  = head_entry[INSTR_W +: CTRL_W];

    // ready_en_q keeps InstrReady low until the first edge after reset release.
    assign InstrReady = ready_en_q && (count_q != FULL_CNT) && !Flush;
    assign push       = InstrValid && InstrReady;
    assign pop        = out_valid && OutReady;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        mc_op_d   = mc_op_q;
        out_valid = 1'b0;
        start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_valid) begin
                    if (head_ctrl.ismc) begin
                        // An op left running by a flush must finish before a new start.
                        if (!MCycle_Busy) begin
                            state_d = ST_START;
                            mc_op_d = head_ctrl.mcop;
                        end
                    end else begin
                        out_valid = 1'b1;
                    end
                end
            end
            ST_START: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = ST_MC_WAIT;
            end
            ST_MC_WAIT: begin
                if (cnt_q != TMO_CNT) begin
                    cnt_d = cnt_q + TMO_ONE;
                end
                if (cnt_q == TMO_LAST) begin
                    tmo_d = 1'b1;
                end
                if (!MCycle_Busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = head_valid;
                if (head_valid && OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (Flush) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            mc_op_d   = mc_op_q;
            out_valid = 1'b0;
            start     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ready_en_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            mc_op_q    <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            mc_op_q    <= mc_op_d;
            if (Flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                if (push && !pop) begin
                    count_q <= count_q + CNT_ONE;
                end else if (pop && !push) begin
                    count_q <= count_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dec_undef, dec_ctrl, InstrIn};
        end
    end

    assign OutValid        = out_valid;
    assign CtrlOut         = head_valid ? head_ctrl : '0;
    assign InstrOut        = head_valid ? head_entry[INSTR_W-1:0] : '0;
    assign Undef           = head_valid && head_entry[ENTRY_W-1];
    assign Start_MCycle    = start;
    assign MCycleOp_MCycle = mc_op_q;
    assign McTimeout       = tmo_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
`timescale 1ns/1ps
module tb_decode_issue_queue;

    localparam int MC_TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic        Flush = 1'b0;
    logic [31:0] InstrIn = '0;
    logic        InstrValid = 1'b0;
    logic        InstrReady;
    logic [17:0] CtrlOut;
    logic [31:0] InstrOut;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic        Start_MCycle;
    logic        MCycleOp_MCycle;
    logic        MCycle_Busy = 1'b0;
    logic        Undef;
    logic        McTimeout;

    int tests = 0;
    int fails = 0;

    decode_issue_queue #(.DEPTH(2), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(7)) dut (
        .CLK             (CLK),
        .RESETn          (RESETn),
        .Flush           (Flush),
        .InstrIn         (InstrIn),
        .InstrValid      (InstrValid),
        .InstrReady      (InstrReady),
        .CtrlOut         (CtrlOut),
        .InstrOut        (InstrOut),
        .OutValid        (OutValid),
        .OutReady        (OutReady),
        .Start_MCycle    (Start_MCycle),
        .MCycleOp_MCycle (MCycleOp_MCycle),
        .MCycle_Busy     (MCycle_Busy),
        .Undef           (Undef),
        .McTimeout       (McTimeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [17:0] ctrl;
        logic        undef;
    } vec_t;

    function automatic logic [17:0] mk(input logic regw, input logic memw, input logic memtoreg,
                                        input logic alusrc, input logic [1:0] immsrc, input logic [1:0] regsrc,
                                        input logic [3:0] alu, input logic [1:0] flagw, input logic nowrite,
                                        input logic pcs, input logic ismc, input logic mcop);
        return {mcop, ismc, pcs, nowrite, flagw, alu, regsrc, immsrc, alusrc, memtoreg, memw, regw};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    vec_t vecs[12];
    logic [17:0] mul_ctrl;

    initial begin
        vecs[0]  = '{32'hE2821005, mk(1,0,0,1,2'b00,2'b00,4'b0100,2'b00,0,0,0,0), 1'b0};
        vecs[1]  = '{32'hE3510000, mk(1,0,0,1,2'b00,2'b00,4'b1010,2'b11,1,0,0,0), 1'b0};
        vecs[2]  = '{32'hE5821004, mk(0,1,0,1,2'b01,2'b10,4'b0100,2'b00,0,0,0,0), 1'b0};
        vecs[3]  = '{32'hE0910003, mk(1,0,0,0,2'b00,2'b00,4'b0100,2'b11,0,0,0,0), 1'b0};
        vecs[4]  = '{32'hE1B00001, mk(1,0,0,0,2'b00,2'b00,4'b1101,2'b10,0,0,0,0), 1'b0};
        vecs[5]  = '{32'hE5912008, mk(1,0,1,1,2'b01,2'b00,4'b0100,2'b00,0,0,0,0), 1'b0};
        vecs[6]  = '{32'hE5021004, mk(0,1,0,1,2'b01,2'b10,4'b0010,2'b00,0,0,0,0), 1'b0};
        vecs[7]  = '{32'hEA000002, mk(0,0,0,1,2'b10,2'b01,4'b0100,2'b00,0,1,0,0), 1'b0};
        vecs[8]  = '{32'hEE000000, 18'd0, 1'b1};
        vecs[9]  = '{32'hE28FF004, mk(1,0,0,1,2'b00,2'b00,4'b0100,2'b00,0,1,0,0), 1'b0};
        vecs[10] = '{32'hE1110002, mk(1,0,0,0,2'b00,2'b00,4'b1000,2'b10,1,0,0,0), 1'b0};
        vecs[11] = '{32'hE0000281, mk(1,0,0,0,2'b00,2'b00,4'b0000,2'b00,0,0,0,0), 1'b0};
        mul_ctrl = mk(1,0,0,0,2'b00,2'b00,4'b0000,2'b00,0,0,1,0);

        // Reset state
        #1 RESETn = 1'b0;
        #1;
        chk("rst_ready", InstrReady, 0);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_ctrl", CtrlOut, 0);
        chk("rst_start", Start_MCycle, 0);
        chk("rst_tmo", McTimeout, 0);
        chk("rst_undef", Undef, 0);
        chk("rst_mcop", MCycleOp_MCycle, 0);
        repeat (2) @(posedge CLK);
        #2 RESETn = 1'b1;
        tick(); mid();
        chk("post_rst_ready", InstrReady, 1);
        chk("post_rst_outvalid", OutValid, 0);
        tick();

        // Table-driven decode through the queue, one entry at a time
        OutReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            InstrIn = vecs[i].instr;
            InstrValid = 1'b1;
            tick();
            InstrValid = 1'b0;
            InstrIn = '0;
            mid();
            chk($sformatf("vec%0d_valid", i), OutValid, 1);
            chk($sformatf("vec%0d_ctrl", i), CtrlOut, vecs[i].ctrl);
            chk($sformatf("vec%0d_instr", i), InstrOut, vecs[i].instr);
            chk($sformatf("vec%0d_undef", i), Undef, vecs[i].undef);
            tick();
        end
        mid();
        chk("drain_outvalid", OutValid, 0);
        tick();

        // MUL with Busy high for 4 cycles
        InstrIn = 32'hE0000291; InstrValid = 1'b1;
        tick(); InstrValid = 1'b0;
        mid();
        chk("mul_idle_ov", OutValid, 0);
        chk("mul_idle_start", Start_MCycle, 0);
        tick(); mid();
        chk("mul_start", Start_MCycle, 1);
        chk("mul_op", MCycleOp_MCycle, 0);
        chk("mul_start_ov", OutValid, 0);
        tick();
        MCycle_Busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk($sformatf("mul_wait%0d_start", k), Start_MCycle, 0);
            chk($sformatf("mul_wait%0d_ov", k), OutValid, 0);
            tick();
        end
        MCycle_Busy = 1'b0;
        mid();
        chk("mul_busyfall_ov", OutValid, 0);
        chk("mul_busyfall_op", MCycleOp_MCycle, 0);
        tick(); mid();
        chk("mul_done_ov", OutValid, 1);
        chk("mul_done_ctrl", CtrlOut, mul_ctrl);
        chk("mul_done_start", Start_MCycle, 0);
        tick(); mid();
        chk("mul_popped_ov", OutValid, 0);
        chk("mul_no_tmo", McTimeout, 0);
        tick();

        // Fill with OutReady low, check order, then flush
        OutReady = 1'b0;
        InstrIn = 32'hE2821005; InstrValid = 1'b1;
        mid(); chk("fill0_ready", InstrReady, 1);
        tick();
        InstrIn = 32'hE3510000;
        mid(); chk("fill1_ready", InstrReady, 1);
        tick();
        InstrIn = 32'hE5821004;
        mid();
        chk("full_ready", InstrReady, 0);
        chk("full_ov", OutValid, 1);
        chk("full_head", InstrOut, 32'hE2821005);
        tick();
        InstrValid = 1'b0; OutReady = 1'b1;
        mid(); chk("full_hold_ready", InstrReady, 0);
        tick();
        OutReady = 1'b0;
        mid();
        chk("order_head", InstrOut, 32'hE3510000);
        chk("after_pop_ready", InstrReady, 1);
        Flush = 1'b1;
        #1 chk("flush_ready_gate", InstrReady, 0);
        tick();
        Flush = 1'b0;
        mid();
        chk("flush_ov", OutValid, 0);
        chk("flush_ready", InstrReady, 1);
        tick();

        // Flush during MC_WAIT; next MC head must wait for Busy to drop
        OutReady = 1'b1;
        InstrIn = 32'hE0000291; InstrValid = 1'b1;
        tick(); InstrValid = 1'b0;
        tick(); mid();
        chk("fmc_start", Start_MCycle, 1);
        tick();
        MCycle_Busy = 1'b1;
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        mid();
        chk("fmc_flush_ov", OutValid, 0);
        chk("fmc_flush_start", Start_MCycle, 0);
        InstrIn = 32'hE0000291; InstrValid = 1'b1;
        tick(); InstrValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk($sformatf("guard%0d_start", k), Start_MCycle, 0);
            chk($sformatf("guard%0d_ov", k), OutValid, 0);
            tick();
        end
        MCycle_Busy = 1'b0;
        mid(); chk("guard_last_start", Start_MCycle, 0);
        tick(); mid();
        chk("guard_release_start", Start_MCycle, 1);
        tick();
        tick(); mid();
        chk("guard_done_ov", OutValid, 1);
        tick();

        // Timeout: Busy held ~70 cycles
        InstrIn = 32'hE0000291; InstrValid = 1'b1;
        tick(); InstrValid = 1'b0;
        tick(); mid();
        chk("tmo_start", Start_MCycle, 1);
        MCycle_Busy = 1'b1;
        repeat (MC_TIMEOUT) tick();
        mid();
        chk("tmo_before", McTimeout, 0);
        tick(); mid();
        chk("tmo_at", McTimeout, 1);
        chk("tmo_op_stable", MCycleOp_MCycle, 0);
        repeat (5) tick();
        mid();
        chk("tmo_still_wait_ov", OutValid, 0);
        MCycle_Busy = 1'b0;
        tick(); mid();
        chk("tmo_done_ov", OutValid, 1);
        tick(); mid();
        chk("tmo_sticky", McTimeout, 1);

        // Async reset with an entry queued
        OutReady = 1'b0;
        InstrIn = 32'hE2821005; InstrValid = 1'b1;
        tick(); InstrValid = 1'b0;
        mid(); chk("pre_rst_ov", OutValid, 1);
        #1 RESETn = 1'b0;
        #1;
        chk("arst_tmo", McTimeout, 0);
        chk("arst_ov", OutValid, 0);
        chk("arst_ctrl", CtrlOut, 0);
        chk("arst_ready", InstrReady, 0);
        tick();
        RESETn = 1'b1;
        tick(); mid();
        chk("arst_rel_ready", InstrReady, 1);
        chk("arst_rel_ov", OutValid, 0);
        tick();

        // Divide encoding
        OutReady = 1'b1;
        InstrIn = 32'hE7F000F0; InstrValid = 1'b1;
        tick(); InstrValid = 1'b0;
        mid();
`ifdef DECODER_DIV_EN
        chk("div_idle_ov", OutValid, 0);
        chk("div_undef", Undef, 0);
        tick(); mid();
        chk("div_start", Start_MCycle, 1);
        chk("div_op", MCycleOp_MCycle, 1);
        tick();
        tick(); mid();
        chk("div_done_ov", OutValid, 1);
        chk("div_ctrl", CtrlOut, mk(1,0,0,0,2'b00,2'b00,4'b0000,2'b00,0,0,1,1));
        tick();
`else
        chk("div_undef", Undef, 1);
        chk("div_ov", OutValid, 1);
        chk("div_ctrl", CtrlOut, 0);
        chk("div_no_start", Start_MCycle, 0);
        tick(); mid();
        chk("div_pop_start", Start_MCycle, 0);
        chk("div_pop_ov", OutValid, 0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1);
    end

endmodule
